pipe_hazard_ctrl: RTL and testbench

Central stall/flush controller for the five-stage integer/FP pipeline. It drives the write-enable and bubble-insert controls of the PC, IF/ID, ID/EX and EX/MEM registers. It resolves three hazard classes:
- integer and FP load-use hazards;
- taken-branch squashes;
- multi-cycle FP operations (mul/div) that must hold EX for several cycles.

It also keeps saturating stall and flush counters for performance debug.

---
 rtl/pipe_hazard_ctrl.sv | 151 +++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl
// Central stall/flush controller for the five-stage integer/FP pipeline.
// Drives the load enables and bubble/flush controls of PC, IF/ID, ID/EX and
// EX/MEM. It resolves integer and FP load-use hazards, taken-branch squashes
// and multi-cycle FP operations that hold EX. It also keeps saturating stall
// and flush counters for performance debug.
//
// Ports:
//   clk, rst_n                      clock, synchronous active-low reset
//   idRs/idRt, idUsesRs/idUsesRt    integer sources of the ID instruction
//   idFpRs/idFpRt, idUsesFp*        FP sources of the ID instruction
//   exMemRead/exRW                  integer load in EX and its destination
//   exFpLoad/exFpRW                 FP load in EX and its destination
//   exFpLongOp                      EX op class (00 none, 01 mul, 10/11 div)
//   branchTakenEx                   branch in EX resolved taken
//   pcWrite, ifIdWrite, ifIdFlush   PC / IF/ID controls
//   idExWrite, idExBubble           ID/EX controls
//   exMemBubble                     EX/MEM bubble insert
//   fpBusy                          controller in BUSY state
//   stallCount, flushCount          saturating performance counters
module pipe_hazard_ctrl #(
  parameter int unsigned FP_MUL_LAT = 4,
  parameter int unsigned FP_DIV_LAT = 12
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  idRs,
  input  logic [4:0]  idRt,
  input  logic        idUsesRs,
  input  logic        idUsesRt,
  input  logic [4:0]  idFpRs,
  input  logic [4:0]  idFpRt,
  input  logic        idUsesFpRs,
  input  logic        idUsesFpRt,
  input  logic        exMemRead,
  input  logic [4:0]  exRW,
  input  logic        exFpLoad,
  input  logic [4:0]  exFpRW,
  input  logic [1:0]  exFpLongOp,
  input  logic        branchTakenEx,
  output logic        pcWrite,
  output logic        ifIdWrite,
  output logic        ifIdFlush,
  output logic        idExWrite,
  output logic        idExBubble,
  output logic        exMemBubble,
  output logic        fpBusy,
  output logic [15:0] stallCount,
  output logic [15:0] flushCount
);

  typedef enum logic {ST_RUN, ST_BUSY} state_t;

  state_t      state_reg, state_next;
  logic [3:0]  cnt_reg, cnt_next;
  logic [15:0] stall_cnt_reg, flush_cnt_reg;

  // Source operand pairs, index 0 = rs, index 1 = rt.
  logic [1:0][4:0] int_src, fp_src;
  logic [1:0]      int_use, fp_use;
  logic [1:0]      int_hit, fp_hit;

  assign int_src = {idRt, idRs};
  assign int_use = {idUsesRt, idUsesRs};
  assign fp_src  = {idFpRt, idFpRs};
  assign fp_use  = {idUsesFpRt, idUsesFpRs};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_src
      assign int_hit[gi] = int_use[gi] && (int_src[gi] == exRW);
      assign fp_hit[gi]  = fp_use[gi] && (fp_src[gi] == exFpRW);
    end
  endgenerate

  logic load_use_int, load_use_fp, load_use;
  logic freeze, flush_now;
  logic [3:0] lat_sel;

  // Integer r0 is hardwired zero, so a load to it never creates a hazard.
  // FP register 0 is a real register and has no such exclusion.
  assign load_use_int = exMemRead && (exRW != 5'd0) && (|int_hit);
  assign load_use_fp  = exFpLoad && (|fp_hit);
  assign load_use     = load_use_int || load_use_fp;

  assign lat_sel = (exFpLongOp == 2'b01) ? FP_MUL_LAT[3:0] : FP_DIV_LAT[3:0];

  // Freeze covers the issue cycle in RUN plus every BUSY cycle before the
  // release cycle (cnt==0); during it the EX contents are held.
  assign freeze    = ((state_reg == ST_RUN) && (exFpLongOp != 2'b00)) ||
                     ((state_reg == ST_BUSY) && (cnt_reg != 4'd0));
  assign flush_now = rst_n && !freeze && branchTakenEx;

  always_comb begin
    pcWrite     = 1'b1;
    ifIdWrite   = 1'b1;
    ifIdFlush   = 1'b0;
    idExWrite   = 1'b1;
    idExBubble  = 1'b0;
    exMemBubble = 1'b0;
    fpBusy      = (state_reg == ST_BUSY);
    state_next  = ST_RUN;
    cnt_next    = 4'd0;

    if (!rst_n) begin
      pcWrite     = 1'b0;
      ifIdFlush   = 1'b1;
      idExBubble  = 1'b1;
      exMemBubble = 1'b1;
      fpBusy      = 1'b0;
    end else if (freeze) begin
      pcWrite     = 1'b0;
      ifIdWrite   = 1'b0;
      idExWrite   = 1'b0;
      exMemBubble = 1'b1;
      state_next  = ST_BUSY;
      // LAT-2 leaves LAT-1 freeze cycles followed by one release cycle.
      cnt_next    = (state_reg == ST_RUN) ? (lat_sel - 4'd2) : (cnt_reg - 4'd1);
    end else if (branchTakenEx) begin
      // Any load-use hazard is moot: the dependent instruction is squashed.
      ifIdFlush   = 1'b1;
      idExBubble  = 1'b1;
    end else if (load_use) begin
      pcWrite     = 1'b0;
      ifIdWrite   = 1'b0;
      idExBubble  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= ST_RUN;
      cnt_reg       <= 4'd0;
      stall_cnt_reg <= 16'd0;
      flush_cnt_reg <= 16'd0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      if (!pcWrite && (stall_cnt_reg != 16'hFFFF)) begin
        stall_cnt_reg <= stall_cnt_reg + 16'd1;
      end
      if (flush_now && (flush_cnt_reg != 16'hFFFF)) begin
        flush_cnt_reg <= flush_cnt_reg + 16'd1;
      end
    end
  end

  assign stallCount = stall_cnt_reg;
  assign flushCount = flush_cnt_reg;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed stimulus with
// hand-computed literal checks, plus an occupancy-based reference model
// compared against every DUT output on each falling edge.
module tb_pipe_hazard_ctrl;
  localparam int MUL_LAT = 4;
  localparam int DIV_LAT = 12;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [4:0]  idRs, idRt, idFpRs, idFpRt, exRW, exFpRW;
  logic        idUsesRs, idUsesRt, idUsesFpRs, idUsesFpRt;
  logic        exMemRead, exFpLoad, branchTakenEx;
  logic [1:0]  exFpLongOp;
  logic        pcWrite, ifIdWrite, ifIdFlush, idExWrite, idExBubble, exMemBubble, fpBusy;
  logic [15:0] stallCount, flushCount;

  pipe_hazard_ctrl #(.FP_MUL_LAT(MUL_LAT), .FP_DIV_LAT(DIV_LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .idRs(idRs), .idRt(idRt), .idUsesRs(idUsesRs), .idUsesRt(idUsesRt),
    .idFpRs(idFpRs), .idFpRt(idFpRt), .idUsesFpRs(idUsesFpRs), .idUsesFpRt(idUsesFpRt),
    .exMemRead(exMemRead), .exRW(exRW), .exFpLoad(exFpLoad), .exFpRW(exFpRW),
    .exFpLongOp(exFpLongOp), .branchTakenEx(branchTakenEx),
    .pcWrite(pcWrite), .ifIdWrite(ifIdWrite), .ifIdFlush(ifIdFlush),
    .idExWrite(idExWrite), .idExBubble(idExBubble), .exMemBubble(exMemBubble),
    .fpBusy(fpBusy), .stallCount(stallCount), .flushCount(flushCount)
  );

  int total = 0;
  int bad   = 0;
  bit cmp_en = 0;

  // Reference model: a long op is tracked by how many cycles it has spent
  // in EX; cycles before the last one are freeze cycles.
  bit m_in_op = 0;
  int m_pos   = 0;
  int m_lat   = 0;
  int m_stall = 0;
  int m_flush = 0;

  function automatic logic [6:0] ctl();
    return {pcWrite, ifIdWrite, ifIdFlush, idExWrite, idExBubble, exMemBubble, fpBusy};
  endfunction

  always @(negedge clk) begin
    logic [6:0] exp_ctl;
    logic [6:0] act_ctl;
    bit luse, start, frz, fl;
    act_ctl = ctl();
    start = 0;
    fl    = 0;
    if (!rst_n) begin
      exp_ctl = 7'b0111110;
    end else begin
      luse = (exMemRead && exRW != 0 &&
              ((idUsesRs && idRs == exRW) || (idUsesRt && idRt == exRW))) ||
             (exFpLoad && ((idUsesFpRs && idFpRs == exFpRW) || (idUsesFpRt && idFpRt == exFpRW)));
      start = !m_in_op && (exFpLongOp != 2'b00);
      frz   = start || (m_in_op && (m_pos < m_lat - 1));
      if (frz)                begin exp_ctl = {6'b000001, m_in_op}; end
      else if (branchTakenEx) begin exp_ctl = {6'b111110, m_in_op}; fl = 1; end
      else if (luse)          begin exp_ctl = {6'b000110, m_in_op}; end
      else                    begin exp_ctl = {6'b110100, m_in_op}; end
    end
    if (cmp_en) begin
      total++;
      if (act_ctl !== exp_ctl) begin
        bad++;
        $display("FAIL ctl t=%0t act=%b exp=%b (pc,ifw,iff,idw,idb,emb,busy)", $time, act_ctl, exp_ctl);
      end
      total++;
      if (stallCount !== m_stall[15:0]) begin
        bad++;
        $display("FAIL stallCount t=%0t act=%0d exp=%0d", $time, stallCount, m_stall);
      end
      total++;
      if (flushCount !== m_flush[15:0]) begin
        bad++;
        $display("FAIL flushCount t=%0t act=%0d exp=%0d", $time, flushCount, m_flush);
      end
    end
    // Advance the model to the state after the coming rising edge.
    if (!rst_n) begin
      m_in_op = 0; m_pos = 0; m_stall = 0; m_flush = 0;
    end else begin
      if (!exp_ctl[6] && m_stall < 65535) m_stall++;
      if (fl && m_flush < 65535) m_flush++;
      if (start) begin
        m_in_op = 1;
        m_pos   = 1;
        m_lat   = (exFpLongOp == 2'b01) ? MUL_LAT : DIV_LAT;
      end else if (m_in_op) begin
        if (m_pos == m_lat - 1) m_in_op = 0;
        else m_pos++;
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s act=%0d exp=%0d", name, act, exp);
    end else begin
      $display("check %s ok value=%0d", name, act);
    end
  endtask

  task automatic go();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    idRs = 0; idRt = 0; idFpRs = 0; idFpRt = 0; exRW = 0; exFpRW = 0;
    idUsesRs = 0; idUsesRt = 0; idUsesFpRs = 0; idUsesFpRt = 0;
    exMemRead = 0; exFpLoad = 0; branchTakenEx = 0; exFpLongOp = 2'b00;
  endtask

  task automatic run_op(input logic [1:0] op, input int n, input int br_at, output int n_frz);
    n_frz = 0;
    exFpLongOp = op;
    for (int i = 0; i < n; i++) begin
      branchTakenEx = (i == br_at);
      #1;
      if (!pcWrite) n_frz++;
      go();
    end
    idle();
  endtask

  initial begin
    int nf;
    idle();
    rst_n = 0;
    go();
    cmp_en = 1;
    go(); go();
    #1;
    chk("reset_ctl", int'(ctl()), int'(7'b0111110));
    chk("reset_stall", stallCount, 0);
    chk("reset_flush", flushCount, 0);
    rst_n = 1;
    #1;
    chk("idle_ctl", int'(ctl()), int'(7'b1101000));
    go();

    // Integer load-use on rs
    exMemRead = 1; exRW = 5; idRs = 5; idUsesRs = 1;
    #1;
    chk("lu_pcWrite", pcWrite, 0);
    chk("lu_ifIdWrite", ifIdWrite, 0);
    chk("lu_idExBubble", idExBubble, 1);
    go(); idle(); #1;
    chk("lu_stall", stallCount, 1);
    // Load to r0 never stalls
    exMemRead = 1; exRW = 0; idRs = 0; idUsesRs = 1;
    #1; chk("lu_r0_pcWrite", pcWrite, 1);
    go(); #1; chk("lu_r0_stall", stallCount, 1);
    // rt match only counts when rt is used
    idle(); exMemRead = 1; exRW = 7; idRt = 7; idUsesRt = 0;
    #1; chk("lu_rt_unused", pcWrite, 1);
    idUsesRt = 1;
    #1; chk("lu_rt_used", pcWrite, 0);
    go(); idle();
    // FP load-use on register 0
    exFpLoad = 1; exFpRW = 0; idFpRs = 0; idUsesFpRs = 1;
    #1; chk("fplu_f0_pcWrite", pcWrite, 0);
    go(); idle(); #1;
    chk("fplu_stall", stallCount, 3);

    // FP multiply: freeze t0..t2, release t3
    exFpLongOp = 2'b01;
    for (int t = 0; t < 4; t++) begin
      #1;
      chk("mul_pcWrite", pcWrite, (t < 3) ? 0 : 1);
      chk("mul_exMemBubble", exMemBubble, (t < 3) ? 1 : 0);
      chk("mul_fpBusy", fpBusy, (t >= 1) ? 1 : 0);
      go();
    end
    idle(); #1;
    chk("mul_stall", stallCount, 6);
    chk("mul_busy_after", fpBusy, 0);

    // Branch and load-use together: flush wins
    branchTakenEx = 1; exMemRead = 1; exRW = 5; idRs = 5; idUsesRs = 1;
    #1;
    chk("br_ifIdFlush", ifIdFlush, 1);
    chk("br_idExBubble", idExBubble, 1);
    chk("br_pcWrite", pcWrite, 1);
    go(); idle(); #1;
    chk("br_flush", flushCount, 1);
    chk("br_stall", stallCount, 6);

    // Div then mul back-to-back; a branch during freeze is ignored
    exFpLongOp = 2'b10;
    nf = 0;
    for (int i = 0; i < 16; i++) begin
      if (i == 12) exFpLongOp = 2'b01;
      branchTakenEx = (i == 5);
      #1;
      if (!pcWrite) nf++;
      go();
    end
    idle(); #1;
    chk("divmul_freezes", nf, 14);
    chk("divmul_stall", stallCount, 20);
    chk("divmul_flush", flushCount, 1);

    // Code 11 uses the divide latency; branch with long op in RUN: freeze wins
    run_op(2'b11, 12, 0, nf);
    #1;
    chk("op11_freezes", nf, 11);
    chk("op11_stall", stallCount, 31);
    chk("op11_flush", flushCount, 1);

    // Reset in the middle of a divide
    exFpLongOp = 2'b10;
    go(); go();
    rst_n = 0;
    #1; chk("midrst_ctl", int'(ctl()), int'(7'b0111110));
    go();
    #1; chk("midrst_ctl2", int'(ctl()), int'(7'b0111110));
    chk("midrst_stall", stallCount, 0);
    go();
    rst_n = 1; idle();
    #1;
    chk("postrst_busy", fpBusy, 0);
    chk("postrst_ctl", int'(ctl()), int'(7'b1101000));
    chk("postrst_stall", stallCount, 0);
    chk("postrst_flush", flushCount, 0);
    run_op(2'b01, 4, -1, nf);
    #1;
    chk("postrst_mul_freezes", nf, 3);
    chk("postrst_mul_stall", stallCount, 3);

    // Saturation of stallCount
    exMemRead = 1; exRW = 5; idRs = 5; idUsesRs = 1;
    repeat (70000) go();
    #1; chk("sat_stall", stallCount, 65535);
    idle(); go();
    #1; chk("sat_stall_hold", stallCount, 65535);

    cmp_en = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
